// File: rtl/pipe_pkg.sv
// Shared types and widths for the RV32I elastic pipeline-stage registers.
// The state encoding doubles as the occupancy count (0, 1 or 2 entries).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int XLEN          = 32;
  localparam int RV_RD_W       = 5;
  localparam int DEF_PAYLOAD_W = 3 * XLEN;
  localparam int DEF_CTRL_W    = 2;

  function automatic int calc_entry_w(input int payload_w, input int ctrl_w, input int rd_w);
    return payload_w + ctrl_w + rd_w + 1;
  endfunction

  localparam int ENTRY_W = calc_entry_w(DEF_PAYLOAD_W, DEF_CTRL_W, RV_RD_W);

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: W-bit register with load enable and synchronous active-low clear.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage carrying payload, ctrl, rd and regwrite.
// SKID=1 adds a second entry so in_ready comes from a flop instead of out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int RD_W      = RV_RD_W,
  parameter bit SKID      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [RD_W-1:0]      in_rd,
  input  logic                 in_regwrite,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [RD_W-1:0]      out_rd,
  output logic                 out_regwrite,
  output logic [1:0]           occupancy
);

  localparam int ENT_W = calc_entry_w(PAYLOAD_W, CTRL_W, RD_W);

  state_e             state_q;
  state_e             state_d;
  logic [ENT_W-1:0]   in_entry;
  logic [ENT_W-1:0]   head_q;
  logic [ENT_W-1:0]   head_d;
  logic [ENT_W-1:0]   skid_q;
  logic               head_ld;
  logic               head_from_skid;
  logic               skid_ld;
  logic               in_ready_w;
  logic               out_valid_w;
  logic               accept;
  logic               pop;
  logic               head_regwrite;

  assign in_entry    = {in_payload, in_ctrl, in_rd, in_regwrite};
  assign out_valid_w = (state_q != ST_EMPTY);
  assign accept      = in_valid && in_ready_w;
  assign pop         = out_valid_w && out_ready;

  // Flush wins over accept and pop; a flushed input is simply never loaded.
  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            head_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_ld = 1'b1;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d        = ST_ONE;
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    head_d = in_entry;
    if (head_from_skid) head_d = skid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  pipe_entry #(.W(ENT_W)) u_head (
    .clk   (clk),
    .clr_n (rst),
    .ld    (head_ld),
    .d     (head_d),
    .q     (head_q)
  );

  generate
    if (SKID) begin : gen_skid
      logic in_ready_q;
      logic in_ready_d;

      // Registered ready: low exactly when the stage will hold two entries.
      always_comb begin
        in_ready_d = (state_d != ST_TWO);
      end

      always_ff @(posedge clk) begin
        if (!rst) in_ready_q <= 1'b0;
        else      in_ready_q <= in_ready_d;
      end

      pipe_entry #(.W(ENT_W)) u_skid (
        .clk   (clk),
        .clr_n (rst),
        .ld    (skid_ld),
        .d     (in_entry),
        .q     (skid_q)
      );

      assign in_ready_w = in_ready_q;
    end else begin : gen_single
      assign skid_q     = '0;
      assign in_ready_w = rst && (!out_valid_w || out_ready);
    end
  endgenerate

  assign in_ready = in_ready_w;
  assign out_valid = out_valid_w;
  assign {out_payload, out_ctrl, out_rd, head_regwrite} = head_q;
  assign out_regwrite = head_regwrite && out_valid_w;
  assign occupancy    = state_q;

endmodule
